// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: on a miss it requests a whole block from pipelined main memory and streams the words into the data array.
// Optional macro CACHE_FILL_CRIT_WORD_FIRST_EN selects critical-word-first ordering; the default build fills from offset 0 upward.
module cache_fill_fsm #(
    parameter int ADDR_W      = 16,
    parameter int BLOCK_WORDS = 8,
    localparam int OFS_W      = $clog2(BLOCK_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    output logic              fsm_busy,
    output logic              memory_read,
    output logic [ADDR_W-1:0] memory_address,
    input  logic              memory_data_valid,
    input  logic [15:0]       memory_data,
    output logic              write_data_array,
    output logic [OFS_W-1:0]  fill_word,
    output logic [15:0]       fill_data,
    output logic              write_tag_array
);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam logic [OFS_W:0] CNT_BLOCK = (OFS_W + 1)'(BLOCK_WORDS);
    localparam logic [OFS_W:0] CNT_LAST  = (OFS_W + 1)'(BLOCK_WORDS - 1);
    localparam logic [OFS_W:0] CNT_ONE   = (OFS_W + 1)'(1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [OFS_W:0]     req_cnt_q, req_cnt_d;
    logic [OFS_W:0]     rcv_cnt_q, rcv_cnt_d;
    logic [OFS_W-1:0]   req_ofs;
    logic [OFS_W-1:0]   rcv_ofs;
    logic [ADDR_W-1:0]  req_addr;
    logic               unused_bits;

`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
    logic [OFS_W-1:0]   crit_q, crit_d;

    // Offsets wrap modulo the block size through the natural OFS_W-bit overflow.
    assign req_ofs     = req_cnt_q[OFS_W-1:0] + crit_q;
    assign rcv_ofs     = rcv_cnt_q[OFS_W-1:0] + crit_q;
    assign unused_bits = miss_address[0];

    always_comb begin
        crit_d = crit_q;
        if (state_q == IDLE && miss_detected) begin
            crit_d = miss_address[OFS_W:1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crit_q <= '0;
        end else begin
            crit_q <= crit_d;
        end
    end
`else
    assign req_ofs     = req_cnt_q[OFS_W-1:0];
    assign rcv_ofs     = rcv_cnt_q[OFS_W-1:0];
    assign unused_bits = ^miss_address[OFS_W:0];
`endif

    // The offset is OR-ed into the aligned base so a fill never carries into the tag bits.
    assign req_addr = base_q | {{(ADDR_W - OFS_W - 1){1'b0}}, req_ofs, 1'b0};
    assign fsm_busy = (state_q == FILL);

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        req_cnt_d        = req_cnt_q;
        rcv_cnt_d        = rcv_cnt_q;
        memory_read      = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        fill_word        = '0;
        fill_data        = '0;
        write_tag_array  = 1'b0;

        case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    state_d   = FILL;
                    base_d    = {miss_address[ADDR_W-1:OFS_W+1], {(OFS_W + 1){1'b0}}};
                    req_cnt_d = '0;
                    rcv_cnt_d = '0;
                end
            end
            FILL: begin
                if (req_cnt_q < CNT_BLOCK) begin
                    memory_read    = 1'b1;
                    memory_address = req_addr;
                    req_cnt_d      = req_cnt_q + CNT_ONE;
                end
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    fill_word        = rcv_ofs;
                    fill_data        = memory_data;
                    rcv_cnt_d        = rcv_cnt_q + CNT_ONE;
                    if (rcv_cnt_q == CNT_LAST) begin
                        write_tag_array = 1'b1;
                        state_d         = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            req_cnt_q <= '0;
            rcv_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            req_cnt_q <= req_cnt_d;
            rcv_cnt_q <= rcv_cnt_d;
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomized scoreboard bench for cache_fill_fsm with a latency-L pipelined memory stub.
// Honours CACHE_FILL_CRIT_WORD_FIRST_EN when compiled together with the design.
module tb_cache_fill_fsm;

    localparam int ADDR_W = 16;
    localparam int BW     = 8;
    localparam int OFS_W  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              miss_detected = 1'b0;
    logic [ADDR_W-1:0] miss_address = '0;
    logic              fsm_busy;
    logic              memory_read;
    logic [ADDR_W-1:0] memory_address;
    logic              memory_data_valid = 1'b0;
    logic [15:0]       memory_data = '0;
    logic              write_data_array;
    logic [OFS_W-1:0]  fill_word;
    logic [15:0]       fill_data;
    logic              write_tag_array;

    cache_fill_fsm #(.ADDR_W(ADDR_W), .BLOCK_WORDS(BW)) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .fsm_busy          (fsm_busy),
        .memory_read       (memory_read),
        .memory_address    (memory_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .write_data_array  (write_data_array),
        .fill_word         (fill_word),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned       p;
        logic [ADDR_W-1:0] addr;
    } req_t;

    typedef struct {
        int unsigned      p;
        logic [OFS_W-1:0] word;
        logic [15:0]      data;
        logic             tag;
    } wr_t;

    int                checks = 0;
    int                errors = 0;
    int unsigned       cyc = 0;
    int                lat = 4;
    bit                fill_active = 1'b0;
    int unsigned       end_p = 0;
    int                fills = 0;
    req_t              req_q[$];
    wr_t               wr_q[$];
    logic [ADDR_W-1:0] ret_map[int unsigned];

    function automatic logic [15:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory stub: a word returns exactly lat cycles after its request.
    always @(posedge clk) begin
        #1;
        if (ret_map.exists(cyc)) begin
            memory_data_valid = 1'b1;
            memory_data       = mem_word(ret_map[cyc]);
            ret_map.delete(cyc);
        end else begin
            memory_data_valid = 1'b0;
            memory_data       = '0;
        end
    end

    // Monitor, scoreboard and reference model of which cycles are busy.
    always @(negedge clk) begin
        bit   exp_req;
        bit   exp_wr;
        req_t r;
        wr_t  w;
        int   crit;
        int   ofs;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] a;
        if (cyc > 0) begin
            exp_req = (req_q.size() > 0) && (req_q[0].p == cyc);
            checks++;
            if (memory_read !== exp_req) begin
                errors++;
                $display("FAIL req_strobe cyc=%0d: memory_read=%b expected %b", cyc, memory_read, exp_req);
            end
            if (exp_req) begin
                r = req_q.pop_front();
                if (memory_read) begin
                    checks++;
                    if (memory_address !== r.addr) begin
                        errors++;
                        $display("FAIL req_addr cyc=%0d: memory_address=%h expected %h", cyc, memory_address, r.addr);
                    end
                end
            end else if (!memory_read) begin
                checks++;
                if (memory_address !== '0) begin
                    errors++;
                    $display("FAIL req_addr_idle cyc=%0d: memory_address=%h expected 0", cyc, memory_address);
                end
            end
            if (memory_read === 1'b1) ret_map[cyc + lat] = memory_address;

            exp_wr = (wr_q.size() > 0) && (wr_q[0].p == cyc);
            checks++;
            if (write_data_array !== exp_wr) begin
                errors++;
                $display("FAIL wr_strobe cyc=%0d: write_data_array=%b expected %b", cyc, write_data_array, exp_wr);
            end
            if (exp_wr) begin
                w = wr_q.pop_front();
                if (write_data_array) begin
                    checks++;
                    if (fill_word !== w.word || fill_data !== w.data || write_tag_array !== w.tag) begin
                        errors++;
                        $display("FAIL wr_data cyc=%0d: word=%0d data=%h tag=%b expected word=%0d data=%h tag=%b",
                                 cyc, fill_word, fill_data, write_tag_array, w.word, w.data, w.tag);
                    end
                end
            end else if (!write_data_array) begin
                checks++;
                if (write_tag_array !== 1'b0 || (!fill_active && (fill_word !== '0 || fill_data !== '0))) begin
                    errors++;
                    $display("FAIL no_write cyc=%0d: tag=%b word=%0d data=%h expected all 0", cyc, write_tag_array, fill_word, fill_data);
                end
            end

            checks++;
            if (fsm_busy !== fill_active) begin
                errors++;
                $display("FAIL busy cyc=%0d: fsm_busy=%b expected %b", cyc, fsm_busy, fill_active);
            end

            if (rst) begin
                fill_active = 1'b0;
                req_q.delete();
                wr_q.delete();
            end else if (fill_active) begin
                if (cyc == end_p) fill_active = 1'b0;
            end else if (miss_detected) begin
                base = miss_address & ~ADDR_W'(2 * BW - 1);
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
                crit = int'(miss_address[OFS_W:1]);
`else
                crit = 0;
`endif
                for (int i = 0; i < BW; i++) begin
                    ofs = (crit + i) % BW;
                    a   = base | ADDR_W'(ofs * 2);
                    req_q.push_back('{p: cyc + 1 + i, addr: a});
                    wr_q.push_back('{p: cyc + 1 + lat + i, word: OFS_W'(ofs), data: mem_word(a), tag: (i == BW - 1)});
                end
                fill_active = 1'b1;
                end_p       = cyc + BW + lat;
                fills++;
                $display("fill %0d: miss_address=%h base=%h first_word=%0d latency=%0d accepted in cycle %0d",
                         fills, miss_address, base, crit, lat, cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((fill_active || ret_map.size() > 0) && guard < 300) begin
            tick(1);
            guard++;
        end
        if (guard >= 300) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: model still busy after %0d cycles", guard);
        end
    endtask

    task automatic do_miss(input logic [ADDR_W-1:0] a, input int l);
        lat           = l;
        miss_address  = a;
        miss_detected = 1'b1;
        tick(1);
        miss_detected = 1'b0;
        miss_address  = ADDR_W'($urandom);
    endtask

    task automatic idle_pulses();
        for (int k = 1; k <= 3; k++) ret_map[cyc + k] = ADDR_W'($urandom);
        wait_idle();
    endtask

    initial begin
        int l;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({fsm_busy, memory_read, write_data_array, write_tag_array} !== 4'b0 ||
            memory_address !== '0 || fill_word !== '0 || fill_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b rd=%b addr=%h wr=%b word=%0d data=%h tag=%b expected all 0",
                     fsm_busy, memory_read, memory_address, write_data_array, fill_word, fill_data, write_tag_array);
        end
        tick(2);
        rst = 1'b0;
        tick(2);

        idle_pulses();
        do_miss(16'h1236, 4);
        wait_idle();
        do_miss(16'hFFFE, 3);
        wait_idle();
        do_miss(16'h0001, 1);
        wait_idle();

        // Miss held high with a changing address: only idle-cycle addresses start fills.
        lat           = 3;
        miss_detected = 1'b1;
        for (int i = 0; i < 40; i++) begin
            miss_address = ADDR_W'($urandom);
            tick(1);
        end
        miss_detected = 1'b0;
        wait_idle();

        // Reset in the sixth fill cycle; stale returns must not be written.
        do_miss(16'h1236, 4);
        tick(5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        wait_idle();

        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 3) == 0) idle_pulses();
            tick($urandom_range(0, 3));
            l = $urandom_range(1, 6);
            do_miss(ADDR_W'($urandom), l);
            if ($urandom_range(0, 4) == 0) begin
                tick($urandom_range(0, BW + l));
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
            end
            wait_idle();
        end

        tick(2);
        checks++;
        if (req_q.size() != 0 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d requests and %0d writes outstanding, expected 0", req_q.size(), wr_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish by %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
